cdu_read_counter_bank: RTL and testbench
========================================

# cdu_read_counter_bank

Multi-channel CDU read-counter bank. For each gimbal/optics channel it integrates the up/down error-angle levels into a WIDTH-bit read counter (full scale = 360°) at each 25.6 kpps count strobe. It also keeps a signed backlog of counts not yet delivered to the AGC and drains that backlog as PCDU/MCDU increment requests through a round-robin valid/ready port. It sits between the error-angle logic (UPLVL/DNLVL per channel) and the AGC counter-increment interface, replacing the single-channel read counter with a parametrised bank.

## Interface
- CHANNELS, 3, number of independent read channels (1..8)
- WIDTH, 16, read-counter width; LSB = 360°/2^WIDTH
- PEND_W, 4, width of signed per-channel backlog counter (≥2)
- CHW, $clog2(CHANNELS) (min 1), derived; width of channel index

- CLOCKH  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- PS25KH  in  1  count strobe, one CLOCKH cycle high per count period
- UPLVL  in  CHANNELS  per-channel count-up level
- DNLVL  in  CHANNELS  per-channel count-down level
- zero_req  in  CHANNELS  per-channel CDU zero command, level
- angle  out  CHANNELS*WIDTH  read counters, channel i at [i*WIDTH +: WIDTH]
- pend_ovf  out  CHANNELS  sticky backlog-saturation flags
- inc_valid  out  1  increment request to AGC
- inc_chan  out  CHW  channel of presented request
- inc_minus  out  1  0 = PCDU (+1), 1 = MCDU (−1)
- inc_ready  in  1  AGC accepts request; handshake = inc_valid & inc_ready

## Operation
- Count delta per channel on a PS25KH cycle:
  - UPLVL only: +1
  - DNLVL only: −1
  - both or neither: 0
  - no count when PS25KH is low
- angle[i] += delta, modulo 2^WIDTH; wraps 2^WIDTH−1 → 0 and 0 → 2^WIDTH−1.
- Backlog pend[i] += delta − hs_delta, where hs_delta = +1 (plus) / −1 (minus) if channel i is handshaken this cycle. Both terms apply in the same cycle.
- Backlog saturates at ±(2^(PEND_W−1)−1). A count that would exceed the limit is dropped from the backlog only (angle still moves) and sets pend_ovf[i].
- While zero_req[i] is high:
  - angle[i], pend[i] and pend_ovf[i] are held at 0; deltas and handshake updates for i are ignored.
  - The channel is not eligible for arbitration.
  - A request for i that is already presented stays presented until accepted; acceptance leaves pend[i] = 0.
- Arbiter FSM, states IDLE, OFFER:
  - IDLE: if any eligible channel has pend ≠ 0, select the first such channel at or after rr_ptr (wrapping). Register inc_chan and inc_minus = (pend < 0). Go to OFFER.
  - OFFER: inc_valid = 1; inc_chan and inc_minus are held stable. On inc_ready: rr_ptr ← inc_chan+1 (mod CHANNELS), go to IDLE.
- A presented request is never withdrawn. If the backlog changes sign while the request is pending, acceptance still applies the presented sign.

## Timing
- Reset values: angle all 0, pend all 0, pend_ovf 0, inc_valid 0, inc_chan 0, inc_minus 0, rr_ptr 0, FSM IDLE.
- angle updates one cycle after the PS25KH cycle (registered).
- Request latency: pend ≠ 0 visible in IDLE at cycle n → inc_valid high at n+1.
- inc_ready may be high in the same cycle inc_valid rises; handshake completes that cycle.
- One bubble (IDLE) cycle between handshakes, so maximum drain rate is 1 increment per 2 cycles.
- inc_ready while inc_valid is low is ignored.
- zero_req takes effect on the next edge and releases on the next edge after deassertion.
- Asserting rst_n low mid-handshake clears inc_valid immediately (asynchronous); the in-flight increment is lost.

## Structure
- Package cdu_pkg holds:
  - arbiter state enum (IDLE, OFFER)
  - count-delta encoding (DELTA_NONE, DELTA_UP, DELTA_DN)
  - function for backlog saturation limit from PEND_W
- Sub-module cdu_read_channel, generated CHANNELS times:
  - owns angle, pend and pend_ovf
  - inputs: strobe, up, dn, zero, hs, hs_minus
  - outputs: angle, pend_nz, pend_neg, ovf
- Arbiter FSM and rr_ptr live in the top level.

## Test plan
- Reset and count: release rst_n, channel 0 UPLVL=1 for 5 strobes, inc_ready=1 → angle[0]=5, five PCDU handshakes with inc_chan=0, pend returns to 0.
- Wrap: channel 1 DNLVL=1 for 1 strobe from reset → angle[1]=16'hFFFF, one MCDU request on inc_chan=1; then UPLVL for 1 strobe → angle[1]=0.
- Saturation: PEND_W=4, inc_ready=0, channel 2 UPLVL for 10 strobes → angle[2]=10, pend=7, pend_ovf[2]=1; release ready → exactly 7 PCDU handshakes.
- Round-robin: all three channels backlog +2, inc_ready=1 → handshake order 0,1,2,0,1,2, each separated by one idle cycle.
- Simultaneous events: channel 0 pend=+1 presented; DN strobe in the accept cycle → pend=−1, next request MCDU. Separately, zero_req[0] asserted during OFFER → request held, accepted, angle[0]=0, pend=0, no further requests.
- Mid-operation reset: pulse rst_n low while inc_valid=1 and pend=+3 → all outputs at reset values, no request after release.

Source files
------------

// File: rtl/cdu_pkg.sv
// Shared types and helpers for the CDU read-counter bank: arbiter states,
// count-delta encoding and the backlog saturation limit.
package cdu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        DELTA_NONE = 2'b00,
        DELTA_UP   = 2'b01,
        DELTA_DN   = 2'b10
    } delta_e;

    // Largest backlog magnitude a signed pend_w-bit counter may hold.
    function automatic int pend_limit(input int pend_w);
        return (1 << (pend_w - 1)) - 1;
    endfunction

    // Both levels, or neither, cancel; nothing counts outside the strobe.
    function automatic delta_e count_delta(input logic strobe, input logic up, input logic dn);
        if (!strobe || (up == dn)) begin
            return DELTA_NONE;
        end
        return up ? DELTA_UP : DELTA_DN;
    endfunction

endpackage

// File: rtl/cdu_read_channel.sv
// One CDU read channel: the angle read counter plus the signed backlog of
// counts still owed to the AGC, with a sticky saturation flag.
module cdu_read_channel
    import cdu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int PEND_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic             up,
    input  logic             dn,
    input  logic             zero,
    input  logic             hs,
    input  logic             hs_minus,
    output logic [WIDTH-1:0] angle,
    output logic             pend_nz,
    output logic             pend_neg,
    output logic             ovf
);

    // Two guard bits so the raw sum of backlog, count and handshake never wraps.
    localparam int EXT = PEND_W + 2;
    localparam logic signed [EXT-1:0] LIM_POS = EXT'(pend_limit(PEND_W));
    localparam logic signed [EXT-1:0] LIM_NEG = -LIM_POS;

    logic [WIDTH-1:0]      angle_q, angle_d;
    logic [PEND_W-1:0]     pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    delta_e                delta;
    logic signed [EXT-1:0] cnt_step, hs_step, pend_sum;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        delta    = count_delta(strobe, up, dn);
        cnt_step = '0;
        angle_d  = angle_q;
        case (delta)
            DELTA_UP: begin
                cnt_step = EXT'(1);
                angle_d  = angle_q + WIDTH'(1);
            end
            DELTA_DN: begin
                cnt_step = '1;
                angle_d  = angle_q - WIDTH'(1);
            end
            default: ;
        endcase

        hs_step = '0;
        if (hs) begin
            hs_step = hs_minus ? '1 : EXT'(1);
        end

        // An accepted increment always applies its presented sign, even if the
        // backlog has since crossed zero; clamping absorbs the excess.
        pend_sum = $signed({{2{pend_q[PEND_W-1]}}, pend_q}) + cnt_step - hs_step;
        pend_d   = pend_sum[PEND_W-1:0];
        ovf_d    = ovf_q;
        if (pend_sum > LIM_POS) begin
            pend_d = LIM_POS[PEND_W-1:0];
            ovf_d  = 1'b1;
        end else if (pend_sum < LIM_NEG) begin
            pend_d = LIM_NEG[PEND_W-1:0];
            ovf_d  = 1'b1;
        end

        if (zero) begin
            angle_d = '0;
            pend_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            angle_q <= angle_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign angle    = angle_q;
    assign pend_nz  = |pend_q;
    assign pend_neg = pend_q[PEND_W-1];
    assign ovf      = ovf_q;

endmodule

// File: rtl/cdu_read_counter_bank.sv
// Multi-channel CDU read-counter bank: per-channel read counters and backlogs,
// drained to the AGC as PCDU/MCDU requests through a round-robin handshake.
module cdu_read_counter_bank
    import cdu_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 16,
    parameter int PEND_W   = 4,
    parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLOCKH,
    input  logic                      rst_n,
    input  logic                      PS25KH,
    input  logic [CHANNELS-1:0]       UPLVL,
    input  logic [CHANNELS-1:0]       DNLVL,
    input  logic [CHANNELS-1:0]       zero_req,
    output logic [CHANNELS*WIDTH-1:0] angle,
    output logic [CHANNELS-1:0]       pend_ovf,
    output logic                      inc_valid,
    output logic [CHW-1:0]            inc_chan,
    output logic                      inc_minus,
    input  logic                      inc_ready
);

    arb_state_e          state_q, state_d;
    logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]      inc_chan_q, inc_chan_d;
    logic                inc_minus_q, inc_minus_d;
    logic [CHANNELS-1:0] pend_nz, pend_neg, eligible;
    logic                hs;
    logic                found;
    int                  idx;

    assign hs       = (state_q == OFFER) && inc_ready;
    assign eligible = pend_nz & ~zero_req;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        cdu_read_channel #(
            .WIDTH  (WIDTH),
            .PEND_W (PEND_W)
        ) u_chan (
            .clk      (CLOCKH),
            .rst_n    (rst_n),
            .strobe   (PS25KH),
            .up       (UPLVL[i]),
            .dn       (DNLVL[i]),
            .zero     (zero_req[i]),
            .hs       (hs && (inc_chan_q == CHW'(i))),
            .hs_minus (inc_minus_q),
            .angle    (angle[i*WIDTH +: WIDTH]),
            .pend_nz  (pend_nz[i]),
            .pend_neg (pend_neg[i]),
            .ovf      (pend_ovf[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        inc_chan_d  = inc_chan_q;
        inc_minus_d = inc_minus_q;
        found       = 1'b0;
        idx         = 0;
        case (state_q)
            IDLE: begin
                // Scan from rr_ptr upward, wrapping, and latch the first hit.
                for (int k = 0; k < CHANNELS; k++) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= CHANNELS) begin
                        idx = idx - CHANNELS;
                    end
                    if (!found && eligible[idx[CHW-1:0]]) begin
                        found       = 1'b1;
                        inc_chan_d  = idx[CHW-1:0];
                        inc_minus_d = pend_neg[idx[CHW-1:0]];
                        state_d     = OFFER;
                    end
                end
            end
            OFFER: begin
                if (inc_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (inc_chan_q == CHW'(CHANNELS - 1)) ? '0 : inc_chan_q + CHW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            inc_chan_q  <= '0;
            inc_minus_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            inc_chan_q  <= inc_chan_d;
            inc_minus_q <= inc_minus_d;
        end
    end

    assign inc_valid = (state_q == OFFER);
    assign inc_chan  = inc_chan_q;
    assign inc_minus = inc_minus_q;

endmodule

// File: tb/tb_cdu_read_counter_bank.sv
// Self-checking bench for cdu_read_counter_bank: directed scenarios plus random
// traffic, all compared every cycle against a behavioural channel/arbiter model.
module tb_cdu_read_counter_bank;

    localparam int CH     = 3;
    localparam int WIDTH  = 16;
    localparam int PEND_W = 4;
    localparam int CHW    = 2;
    localparam int LIM    = 7;
    localparam int MOD    = 1 << WIDTH;

    logic                  CLOCKH;
    logic                  rst_n;
    logic                  PS25KH;
    logic [CH-1:0]         UPLVL, DNLVL, zero_req;
    logic [CH*WIDTH-1:0]   angle;
    logic [CH-1:0]         pend_ovf;
    logic                  inc_valid;
    logic [CHW-1:0]        inc_chan;
    logic                  inc_minus;
    logic                  inc_ready;

    cdu_read_counter_bank #(
        .CHANNELS (CH),
        .WIDTH    (WIDTH),
        .PEND_W   (PEND_W)
    ) dut (
        .CLOCKH    (CLOCKH),
        .rst_n     (rst_n),
        .PS25KH    (PS25KH),
        .UPLVL     (UPLVL),
        .DNLVL     (DNLVL),
        .zero_req  (zero_req),
        .angle     (angle),
        .pend_ovf  (pend_ovf),
        .inc_valid (inc_valid),
        .inc_chan  (inc_chan),
        .inc_minus (inc_minus),
        .inc_ready (inc_ready)
    );

    initial CLOCKH = 1'b0;
    always #5 CLOCKH = ~CLOCKH;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int m_angle [CH];
    int m_pend  [CH];
    bit m_ovf   [CH];
    bit m_offer;
    int m_chan;
    bit m_minus;
    int m_rr;

    // Handshakes observed on the DUT port
    int hs_chan [$];
    int hs_minus[$];
    int hs_cyc  [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_angle[i] = 0;
            m_pend[i]  = 0;
            m_ovf[i]   = 1'b0;
        end
        m_offer = 1'b0;
        m_chan  = 0;
        m_minus = 1'b0;
        m_rr    = 0;
    endtask

    task automatic compare_all();
        logic [CH*WIDTH-1:0] ea;
        logic [CH-1:0]       eo;
        for (int i = 0; i < CH; i++) begin
            ea[i*WIDTH +: WIDTH] = WIDTH'(m_angle[i]);
            eo[i]                = m_ovf[i];
        end
        chk("angle", angle, ea);
        chk("pend_ovf", pend_ovf, eo);
        chk("inc_valid", inc_valid, m_offer);
        if (m_offer) begin
            chk("inc_chan", inc_chan, m_chan);
            chk("inc_minus", inc_minus, m_minus);
        end
    endtask

    task automatic clear_log();
        hs_chan.delete();
        hs_minus.delete();
        hs_cyc.delete();
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare after the edge.
    task automatic step();
        int  n_angle[CH];
        int  n_pend [CH];
        bit  n_ovf  [CH];
        bit  n_offer, n_minus, hs;
        int  n_chan, n_rr, d, h, p, c;
        hs = m_offer && (inc_ready === 1'b1);
        for (int i = 0; i < CH; i++) begin
            d = 0;
            if (PS25KH && UPLVL[i] && !DNLVL[i]) d = 1;
            else if (PS25KH && DNLVL[i] && !UPLVL[i]) d = -1;
            h = (hs && m_chan == i) ? (m_minus ? -1 : 1) : 0;
            p = m_pend[i] + d - h;
            n_ovf[i] = m_ovf[i];
            if (p > LIM) begin
                p = LIM;
                n_ovf[i] = 1'b1;
            end else if (p < -LIM) begin
                p = -LIM;
                n_ovf[i] = 1'b1;
            end
            n_pend[i]  = p;
            n_angle[i] = (m_angle[i] + d + MOD) % MOD;
            if (zero_req[i]) begin
                n_angle[i] = 0;
                n_pend[i]  = 0;
                n_ovf[i]   = 1'b0;
            end
        end
        n_offer = m_offer;
        n_chan  = m_chan;
        n_minus = m_minus;
        n_rr    = m_rr;
        if (m_offer) begin
            if (inc_ready) begin
                n_offer = 1'b0;
                n_rr    = (m_chan + 1) % CH;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                c = (m_rr + k) % CH;
                if (!n_offer && m_pend[c] != 0 && !zero_req[c]) begin
                    n_offer = 1'b1;
                    n_chan  = c;
                    n_minus = (m_pend[c] < 0);
                end
            end
        end
        if (inc_valid && inc_ready) begin
            hs_chan.push_back(int'(inc_chan));
            hs_minus.push_back(int'(inc_minus));
            hs_cyc.push_back(cyc);
        end
        @(posedge CLOCKH);
        #1;
        for (int i = 0; i < CH; i++) begin
            m_angle[i] = n_angle[i];
            m_pend[i]  = n_pend[i];
            m_ovf[i]   = n_ovf[i];
        end
        m_offer = n_offer;
        m_chan  = n_chan;
        m_minus = n_minus;
        m_rr    = n_rr;
        cyc++;
        compare_all();
    endtask

    task automatic strobe(input logic [CH-1:0] up, input logic [CH-1:0] dn, input int gap);
        UPLVL  = up;
        DNLVL  = dn;
        PS25KH = 1'b1;
        step();
        PS25KH = 1'b0;
        UPLVL  = '0;
        DNLVL  = '0;
        repeat (gap) step();
    endtask

    task automatic wait_offer(input string tag);
        for (int k = 0; k < 10; k++) begin
            if (!inc_valid) step();
        end
        chk(tag, inc_valid, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        PS25KH    = 1'b0;
        UPLVL     = '0;
        DNLVL     = '0;
        zero_req  = '0;
        inc_ready = 1'b0;
        model_reset();

        #23;
        chk("rst_angle", angle, '0);
        chk("rst_ovf", pend_ovf, '0);
        chk("rst_valid", inc_valid, 1'b0);
        chk("rst_chan", inc_chan, '0);
        chk("rst_minus", inc_minus, 1'b0);
        @(posedge CLOCKH);
        #1;
        rst_n = 1'b1;

        // Five up-counts on channel 0, drained immediately as PCDU.
        inc_ready = 1'b1;
        clear_log();
        repeat (5) strobe(3'b001, 3'b000, 3);
        repeat (4) step();
        chk("t1_angle0", angle[0 +: WIDTH], 16'd5);
        chk("t1_hs_count", hs_chan.size(), 5);
        for (int i = 0; i < hs_chan.size(); i++) begin
            chk("t1_hs_chan", hs_chan[i], 0);
            chk("t1_hs_minus", hs_minus[i], 0);
        end
        chk("t1_idle", inc_valid, 1'b0);

        // Down-count wraps channel 1 to all-ones, up-count wraps it back.
        clear_log();
        strobe(3'b000, 3'b010, 4);
        chk("t2_wrap_dn", angle[WIDTH +: WIDTH], 16'hFFFF);
        chk("t2_hs_count", hs_chan.size(), 1);
        if (hs_chan.size() == 1) begin
            chk("t2_hs_chan", hs_chan[0], 1);
            chk("t2_hs_minus", hs_minus[0], 1);
        end
        strobe(3'b010, 3'b000, 4);
        chk("t2_wrap_up", angle[WIDTH +: WIDTH], 16'h0000);

        // Backlog saturation on channel 2 with the AGC stalled.
        inc_ready = 1'b0;
        clear_log();
        repeat (10) strobe(3'b100, 3'b000, 1);
        chk("t3_angle2", angle[2*WIDTH +: WIDTH], 16'd10);
        chk("t3_ovf", pend_ovf, 3'b100);
        inc_ready = 1'b1;
        repeat (20) step();
        chk("t3_hs_count", hs_chan.size(), 7);
        for (int i = 0; i < hs_chan.size(); i++) begin
            chk("t3_hs_chan", hs_chan[i], 2);
        end

        // Round-robin drain of +2 on every channel.
        inc_ready = 1'b0;
        repeat (2) strobe(3'b111, 3'b000, 3);
        clear_log();
        inc_ready = 1'b1;
        repeat (14) step();
        chk("t4_hs_count", hs_chan.size(), 6);
        if (hs_chan.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t4_order", hs_chan[i], i % 3);
                if (i > 0) chk("t4_gap", hs_cyc[i] - hs_cyc[i-1], 2);
            end
        end

        // Down-count lands in the accept cycle of a PCDU request.
        inc_ready = 1'b0;
        strobe(3'b001, 3'b000, 0);
        wait_offer("t5_offer_plus");
        chk("t5_plus", inc_minus, 1'b0);
        inc_ready = 1'b1;
        DNLVL     = 3'b001;
        PS25KH    = 1'b1;
        step();
        PS25KH    = 1'b0;
        DNLVL     = '0;
        inc_ready = 1'b0;
        step();
        chk("t5_offer_minus", inc_valid, 1'b1);
        chk("t5_minus", inc_minus, 1'b1);
        chk("t5_minus_chan", inc_chan, 2'd0);
        inc_ready = 1'b1;
        repeat (3) step();

        // Zero command during a presented request.
        inc_ready = 1'b0;
        strobe(3'b001, 3'b000, 0);
        wait_offer("t6_offer");
        zero_req = 3'b001;
        repeat (3) step();
        chk("t6_held", inc_valid, 1'b1);
        inc_ready = 1'b1;
        step();
        repeat (5) step();
        chk("t6_angle0", angle[0 +: WIDTH], 16'd0);
        chk("t6_no_req", inc_valid, 1'b0);
        zero_req = '0;
        repeat (5) step();
        chk("t6_no_req_after", inc_valid, 1'b0);

        // Asynchronous reset while a request is presented with backlog +3.
        inc_ready = 1'b0;
        repeat (3) strobe(3'b001, 3'b000, 1);
        chk("t7_offer", inc_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t7_valid", inc_valid, 1'b0);
        chk("t7_angle", angle, '0);
        chk("t7_ovf", pend_ovf, '0);
        chk("t7_chan", inc_chan, '0);
        chk("t7_minus", inc_minus, 1'b0);
        @(posedge CLOCKH);
        #1;
        rst_n = 1'b1;
        repeat (10) step();
        chk("t7_no_req", inc_valid, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            PS25KH    = ($urandom % 3) == 0;
            UPLVL     = CH'($urandom);
            DNLVL     = CH'($urandom);
            inc_ready = ($urandom % 3) != 0;
            for (int i = 0; i < CH; i++) begin
                zero_req[i] = ($urandom % 24) == 0;
            end
            step();
        end
        PS25KH   = 1'b0;
        zero_req = '0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
